// File: rtl/control_multi_param_if.sv
`default_nettype none
// ============================================================================
// control_multi_param_if : IR fields, memory/mul-div handshakes and datapath controls
// Rev 1.0
// ============================================================================
interface control_multi_param_if;
  logic [6:0] iOpcode;
  logic [6:0] iFunct7;
  logic       iMemReady;
  logic       iMulDivDone;

  logic       oEscreveIR;
  logic       oEscrevePC;
  logic       oEscrevePCCond;
  logic       oEscrevePCBack;
  logic [1:0] oOrigAULA;
  logic [1:0] oOrigBULA;
  logic [1:0] oMem2Reg;
  logic [1:0] oALUOp;
  logic       oOrigPC;
  logic       oIouD;
  logic       oRegWrite;
  logic       oMemWrite;
  logic       oMemRead;
  logic       oMulDivStart;
  logic       oTrap;
  logic       oInstrRetired;
  logic [3:0] oState;

  // Datapath / instruction-register side
  modport master (
    output iOpcode, iFunct7, iMemReady, iMulDivDone,
    input  oEscreveIR, oEscrevePC, oEscrevePCCond, oEscrevePCBack,
    input  oOrigAULA, oOrigBULA, oMem2Reg, oALUOp,
    input  oOrigPC, oIouD, oRegWrite, oMemWrite, oMemRead,
    input  oMulDivStart, oTrap, oInstrRetired, oState
  );

  // Control unit side
  modport slave (
    input  iOpcode, iFunct7, iMemReady, iMulDivDone,
    output oEscreveIR, oEscrevePC, oEscrevePCCond, oEscrevePCBack,
    output oOrigAULA, oOrigBULA, oMem2Reg, oALUOp,
    output oOrigPC, oIouD, oRegWrite, oMemWrite, oMemRead,
    output oMulDivStart, oTrap, oInstrRetired, oState
  );
endinterface
`default_nettype wire

// File: rtl/control_multi_param.sv
`default_nettype none
// ============================================================================
// control_multi_param : parametrised multicycle RV32I control FSM with wait states,
// M-extension handshake, AUIPC, illegal-opcode trap and retire strobe.  Rev 1.0
// ============================================================================
module control_multi_param #(
  parameter int MEM_LAT         = 1,
  parameter int USE_MEM_READY   = 0,
  parameter int ENABLE_MEXT     = 1,
  parameter int TRAP_ON_ILLEGAL = 1
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  control_multi_param_if.slave  bus
);

  generate
    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
      $error("control_multi_param: MEM_LAT must be in 1..15");
    end
  endgenerate

  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OP_JAL    = 7'b1101111;
  localparam logic [6:0] C_OP_JALR   = 7'b1100111;
  localparam logic [6:0] C_OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] C_OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] C_OP_LUI    = 7'b0110111;
  localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_F7_MULDIV = 7'b0000001;
  localparam logic [3:0] C_LAT_LAST  = 4'(MEM_LAT - 1);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_FWAIT  = 4'd1,
    S_DECODE = 4'd2,
    S_ADDR   = 4'd3,
    S_LWAIT  = 4'd4,
    S_LWB    = 4'd5,
    S_SWAIT  = 4'd6,
    S_RTYPE  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10,
    S_JALR   = 4'd11,
    S_LUI    = 4'd12,
    S_AUIPC  = 4'd13,
    S_MULDIV = 4'd14,
    S_TRAP   = 4'd15
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       mdu_first_q, mdu_first_d;

  logic       w_mc;
  logic       w_in_wait;
  logic       w_illegal;
  state_t     w_dec_next;

  logic       w_escreve_ir;
  logic       w_escreve_pc;
  logic       w_escreve_pc_cond;
  logic       w_escreve_pc_back;
  logic [1:0] w_orig_a;
  logic [1:0] w_orig_b;
  logic [1:0] w_mem2reg;
  logic [1:0] w_alu_op;
  logic       w_orig_pc;
  logic       w_iou_d;
  logic       w_reg_write;
  logic       w_mem_write;
  logic       w_mem_read;
  logic       w_muldiv_start;
  logic       w_trap;
  logic       w_retired;

  // Memory completion: external handshake or internal wait-state counter
  assign w_mc      = (USE_MEM_READY != 0) ? bus.iMemReady : (cnt_q == C_LAT_LAST);
  assign w_in_wait = (state_q == S_FWAIT) || (state_q == S_LWAIT) || (state_q == S_SWAIT);

  always_comb begin
    w_dec_next = S_FETCH;
    w_illegal  = 1'b0;
    case (bus.iOpcode)
      C_OP_LOAD, C_OP_STORE: w_dec_next = S_ADDR;
      C_OP_BRANCH:           w_dec_next = S_BRANCH;
      C_OP_JAL:              w_dec_next = S_JAL;
      C_OP_JALR:             w_dec_next = S_JALR;
      C_OP_OPIMM:            w_dec_next = S_RTYPE;
      C_OP_LUI:              w_dec_next = S_LUI;
      C_OP_AUIPC:            w_dec_next = S_AUIPC;
      C_OP_RTYPE: begin
        if (bus.iFunct7 == C_F7_MULDIV) begin
          if (ENABLE_MEXT != 0) w_dec_next = S_MULDIV;
          else                  w_illegal  = 1'b1;
        end else begin
          w_dec_next = S_RTYPE;
        end
      end
      default:               w_illegal = 1'b1;
    endcase
    if (w_illegal) w_dec_next = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;
  end

  always_comb begin
    state_d           = state_q;
    w_escreve_ir      = 1'b0;
    w_escreve_pc      = 1'b0;
    w_escreve_pc_cond = 1'b0;
    w_escreve_pc_back = 1'b0;
    w_orig_a          = 2'b00;
    w_orig_b          = 2'b00;
    w_mem2reg         = 2'b00;
    w_alu_op          = 2'b00;
    w_orig_pc         = 1'b0;
    w_iou_d           = 1'b0;
    w_reg_write       = 1'b0;
    w_mem_write       = 1'b0;
    w_mem_read        = 1'b0;
    w_muldiv_start    = 1'b0;
    w_trap            = 1'b0;
    w_retired         = 1'b0;
    case (state_q)
      S_FETCH: begin
        w_orig_a   = 2'b10;
        w_orig_b   = 2'b01;
        w_mem_read = 1'b1;
        state_d    = S_FWAIT;
      end
      S_FWAIT: begin
        w_orig_a   = 2'b10;
        w_orig_b   = 2'b01;
        w_mem_read = 1'b1;
        if (w_mc) begin
          w_escreve_ir      = 1'b1;
          w_escreve_pc      = 1'b1;
          w_escreve_pc_back = 1'b1;
          state_d           = S_DECODE;
        end
      end
      S_DECODE: begin
        w_orig_a  = 2'b00;
        w_orig_b  = 2'b10;
        state_d   = w_dec_next;
        // Illegal opcode demoted to a NOP still counts as a retired instruction
        w_retired = w_illegal && (TRAP_ON_ILLEGAL == 0);
      end
      S_ADDR: begin
        w_orig_a = 2'b01;
        w_orig_b = 2'b10;
        state_d  = (bus.iOpcode == C_OP_STORE) ? S_SWAIT : S_LWAIT;
      end
      S_LWAIT: begin
        w_iou_d    = 1'b1;
        w_mem_read = 1'b1;
        if (w_mc) state_d = S_LWB;
      end
      S_LWB: begin
        w_mem2reg   = 2'b10;
        w_reg_write = 1'b1;
        w_retired   = 1'b1;
        state_d     = S_FETCH;
      end
      S_SWAIT: begin
        w_iou_d     = 1'b1;
        w_mem_write = 1'b1;
        if (w_mc) begin
          w_retired = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_RTYPE: begin
        w_orig_a = 2'b01;
        w_orig_b = (bus.iOpcode == C_OP_OPIMM) ? 2'b10 : 2'b00;
        w_alu_op = 2'b10;
        state_d  = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_retired   = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        w_orig_a          = 2'b01;
        w_orig_b          = 2'b00;
        w_escreve_pc_cond = 1'b1;
        w_orig_pc         = 1'b1;
        w_alu_op          = 2'b01;
        w_retired         = 1'b1;
        state_d           = S_FETCH;
      end
      S_JAL: begin
        w_escreve_pc = 1'b1;
        w_orig_pc    = 1'b1;
        w_mem2reg    = 2'b01;
        w_reg_write  = 1'b1;
        w_retired    = 1'b1;
        state_d      = S_FETCH;
      end
      S_JALR: begin
        w_orig_a     = 2'b01;
        w_orig_b     = 2'b10;
        w_escreve_pc = 1'b1;
        w_mem2reg    = 2'b01;
        w_reg_write  = 1'b1;
        w_retired    = 1'b1;
        state_d      = S_FETCH;
      end
      S_LUI: begin
        w_orig_b = 2'b10;
        w_alu_op = 2'b11;
        state_d  = S_ALUWB;
      end
      S_AUIPC: begin
        w_orig_a = 2'b00;
        w_orig_b = 2'b10;
        w_alu_op = 2'b00;
        state_d  = S_ALUWB;
      end
      S_MULDIV: begin
        w_orig_a       = 2'b01;
        w_orig_b       = 2'b00;
        w_alu_op       = 2'b10;
        w_muldiv_start = mdu_first_q;
        if (bus.iMulDivDone) state_d = S_ALUWB;
      end
      S_TRAP: begin
        w_trap  = 1'b1;
        state_d = S_TRAP;
      end
    endcase
  end

  // Counter runs only while staying in a wait state, so every entry starts from zero
  assign cnt_d       = (w_in_wait && (state_d == state_q)) ? (cnt_q + 4'd1) : 4'd0;
  assign mdu_first_d = (state_d == S_MULDIV) && (state_q != S_MULDIV);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= S_FETCH;
      cnt_q       <= 4'd0;
      mdu_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mdu_first_q <= mdu_first_d;
    end
  end

  assign bus.oEscreveIR     = w_escreve_ir;
  assign bus.oEscrevePC     = w_escreve_pc;
  assign bus.oEscrevePCCond = w_escreve_pc_cond;
  assign bus.oEscrevePCBack = w_escreve_pc_back;
  assign bus.oOrigAULA      = w_orig_a;
  assign bus.oOrigBULA      = w_orig_b;
  assign bus.oMem2Reg       = w_mem2reg;
  assign bus.oALUOp         = w_alu_op;
  assign bus.oOrigPC        = w_orig_pc;
  assign bus.oIouD          = w_iou_d;
  assign bus.oRegWrite      = w_reg_write;
  assign bus.oMemWrite      = w_mem_write;
  assign bus.oMemRead       = w_mem_read;
  assign bus.oMulDivStart   = w_muldiv_start;
  assign bus.oTrap          = w_trap;
  assign bus.oInstrRetired  = w_retired;
  assign bus.oState         = state_q;

endmodule
`default_nettype wire

// File: tb/tb_control_multi_param.sv
`default_nettype none
// ============================================================================
// tb_control_multi_param : directed checks over five parameter configurations
// Rev 1.0
// ============================================================================
module tb_control_multi_param;

  localparam logic [6:0] C_LOAD   = 7'b0000011;
  localparam logic [6:0] C_STORE  = 7'b0100011;
  localparam logic [6:0] C_BRANCH = 7'b1100011;
  localparam logic [6:0] C_JAL    = 7'b1101111;
  localparam logic [6:0] C_JALR   = 7'b1100111;
  localparam logic [6:0] C_OPIMM  = 7'b0010011;
  localparam logic [6:0] C_RTYPE  = 7'b0110011;
  localparam logic [6:0] C_LUI    = 7'b0110111;
  localparam logic [6:0] C_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_BAD    = 7'b1111111;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  control_multi_param_if bus0 ();
  control_multi_param_if bus1 ();
  control_multi_param_if bus2 ();
  control_multi_param_if bus3 ();
  control_multi_param_if bus4 ();

  control_multi_param #(.MEM_LAT(1), .USE_MEM_READY(0), .ENABLE_MEXT(1), .TRAP_ON_ILLEGAL(1))
    u_dut0 (.iCLK(clk), .iRST_N(rst_n), .bus(bus0.slave));
  control_multi_param #(.MEM_LAT(3), .USE_MEM_READY(0), .ENABLE_MEXT(1), .TRAP_ON_ILLEGAL(1))
    u_dut1 (.iCLK(clk), .iRST_N(rst_n), .bus(bus1.slave));
  control_multi_param #(.MEM_LAT(1), .USE_MEM_READY(1), .ENABLE_MEXT(1), .TRAP_ON_ILLEGAL(1))
    u_dut2 (.iCLK(clk), .iRST_N(rst_n), .bus(bus2.slave));
  control_multi_param #(.MEM_LAT(1), .USE_MEM_READY(0), .ENABLE_MEXT(0), .TRAP_ON_ILLEGAL(0))
    u_dut3 (.iCLK(clk), .iRST_N(rst_n), .bus(bus3.slave));
  control_multi_param #(.MEM_LAT(4), .USE_MEM_READY(0), .ENABLE_MEXT(1), .TRAP_ON_ILLEGAL(1))
    u_dut4 (.iCLK(clk), .iRST_N(rst_n), .bus(bus4.slave));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Leaves the bench at the start of the first post-reset cycle
  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_exec(input logic [6:0] op);
    bus0.iOpcode     = op;
    bus0.iFunct7     = 7'd0;
    bus0.iMulDivDone = 1'b0;
    do_reset();
    repeat (3) to_next();
    @(negedge clk);
  endtask

  initial begin
    int st_add [6]  = '{0, 1, 2, 7, 8, 0};
    int st_lw  [11] = '{0, 1, 1, 1, 2, 3, 4, 4, 4, 5, 0};
    int st_sw  [12] = '{0, 1, 1, 2, 3, 6, 6, 6, 6, 6, 6, 0};
    int rdy_sw [12] = '{1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0};
    int st_mul [12] = '{0, 1, 2, 14, 14, 14, 14, 14, 14, 14, 8, 0};
    int st_f4  [6]  = '{0, 1, 1, 1, 1, 2};

    bus0.iOpcode = 7'd0; bus0.iFunct7 = 7'd0; bus0.iMemReady = 1'b0; bus0.iMulDivDone = 1'b0;
    bus1.iOpcode = 7'd0; bus1.iFunct7 = 7'd0; bus1.iMemReady = 1'b0; bus1.iMulDivDone = 1'b0;
    bus2.iOpcode = 7'd0; bus2.iFunct7 = 7'd0; bus2.iMemReady = 1'b0; bus2.iMulDivDone = 1'b0;
    bus3.iOpcode = 7'd0; bus3.iFunct7 = 7'd0; bus3.iMemReady = 1'b0; bus3.iMulDivDone = 1'b0;
    bus4.iOpcode = 7'd0; bus4.iFunct7 = 7'd0; bus4.iMemReady = 1'b0; bus4.iMulDivDone = 1'b0;

    // Outputs held at FETCH values while reset is asserted
    #12;
    check_eq("rst_state",   32'(bus0.oState),        0);
    check_eq("rst_origa",   32'(bus0.oOrigAULA),     2);
    check_eq("rst_origb",   32'(bus0.oOrigBULA),     1);
    check_eq("rst_memread", 32'(bus0.oMemRead),      1);
    check_eq("rst_retired", 32'(bus0.oInstrRetired), 0);

    // ADD, MEM_LAT=1
    bus0.iOpcode = C_RTYPE;
    bus0.iFunct7 = 7'd0;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_eq($sformatf("add_c%0d_state", c),   32'(bus0.oState),        32'(st_add[c]));
      check_eq($sformatf("add_c%0d_regwr", c),   32'(bus0.oRegWrite),     32'(c == 4));
      check_eq($sformatf("add_c%0d_retired", c), 32'(bus0.oInstrRetired), 32'(c == 4));
      if (c == 3) check_eq("add_aluop", 32'(bus0.oALUOp), 2);
      to_next();
    end

    // LW, MEM_LAT=3
    bus1.iOpcode = C_LOAD;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      check_eq($sformatf("lw_c%0d_state", c),   32'(bus1.oState),     32'(st_lw[c]));
      check_eq($sformatf("lw_c%0d_irwr", c),    32'(bus1.oEscreveIR), 32'(c == 3));
      check_eq($sformatf("lw_c%0d_ioud", c),    32'(bus1.oIouD),      32'(c >= 6 && c <= 8));
      check_eq($sformatf("lw_c%0d_mem2reg", c), 32'(bus1.oMem2Reg),   (c == 9) ? 2 : 0);
      to_next();
    end

    // SW with external ready; pulses outside wait states are ignored
    bus2.iOpcode = C_STORE;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      bus2.iMemReady = rdy_sw[c][0];
      @(negedge clk);
      check_eq($sformatf("sw_c%0d_state", c),   32'(bus2.oState),        32'(st_sw[c]));
      check_eq($sformatf("sw_c%0d_memwr", c),   32'(bus2.oMemWrite),     32'(c >= 5 && c <= 10));
      check_eq($sformatf("sw_c%0d_retired", c), 32'(bus2.oInstrRetired), 32'(c == 10));
      check_eq($sformatf("sw_c%0d_irwr", c),    32'(bus2.oEscreveIR),    32'(c == 2));
      to_next();
    end
    bus2.iMemReady = 1'b0;

    // MUL, done on the 7th MULDIV cycle
    bus0.iOpcode     = C_RTYPE;
    bus0.iFunct7     = 7'b0000001;
    bus0.iMulDivDone = 1'b0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      bus0.iMulDivDone = (c == 9);
      @(negedge clk);
      check_eq($sformatf("mul_c%0d_state", c), 32'(bus0.oState),       32'(st_mul[c]));
      check_eq($sformatf("mul_c%0d_start", c), 32'(bus0.oMulDivStart), 32'(c == 3));
      to_next();
    end

    // MUL with done already high on the entry cycle
    bus0.iMulDivDone = 1'b1;
    do_reset();
    repeat (3) to_next();
    @(negedge clk);
    check_eq("mul0_entry_state", 32'(bus0.oState),       14);
    check_eq("mul0_entry_start", 32'(bus0.oMulDivStart), 1);
    to_next();
    @(negedge clk);
    check_eq("mul0_next_state",  32'(bus0.oState),       8);
    check_eq("mul0_next_start",  32'(bus0.oMulDivStart), 0);
    bus0.iMulDivDone = 1'b0;
    bus0.iFunct7     = 7'd0;

    // Illegal opcode traps and stays trapped until reset
    bus0.iOpcode = C_BAD;
    do_reset();
    repeat (2) to_next();
    @(negedge clk);
    check_eq("trap_dec_retired", 32'(bus0.oInstrRetired), 0);
    to_next();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check_eq($sformatf("trap_c%0d_state", c), 32'(bus0.oState),     15);
      check_eq($sformatf("trap_c%0d_trap", c),  32'(bus0.oTrap),      1);
      check_eq($sformatf("trap_c%0d_pcwr", c),  32'(bus0.oEscrevePC), 0);
      check_eq($sformatf("trap_c%0d_regwr", c), 32'(bus0.oRegWrite),  0);
      to_next();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("trap_rst_state", 32'(bus0.oState), 0);
    check_eq("trap_rst_trap",  32'(bus0.oTrap),  0);

    // TRAP_ON_ILLEGAL=0 / ENABLE_MEXT=0: illegal retires as a NOP
    bus3.iOpcode = C_BAD;
    do_reset();
    repeat (2) to_next();
    @(negedge clk);
    check_eq("nop_dec_retired", 32'(bus3.oInstrRetired), 1);
    check_eq("nop_dec_trap",    32'(bus3.oTrap),         0);
    to_next();
    @(negedge clk);
    check_eq("nop_next_state",  32'(bus3.oState),        0);
    bus3.iOpcode = C_RTYPE;
    bus3.iFunct7 = 7'b0000001;
    do_reset();
    repeat (2) to_next();
    @(negedge clk);
    check_eq("nomext_retired",  32'(bus3.oInstrRetired), 1);
    to_next();
    @(negedge clk);
    check_eq("nomext_state",    32'(bus3.oState),        0);

    // Async reset in the 2nd LWAIT cycle, MEM_LAT=4
    bus4.iOpcode = C_LOAD;
    do_reset();
    repeat (8) to_next();
    @(negedge clk);
    check_eq("lw4_pre_state", 32'(bus4.oState), 4);
    check_eq("lw4_pre_ioud",  32'(bus4.oIouD),  1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("lw4_rst_state", 32'(bus4.oState), 0);
    check_eq("lw4_rst_ioud",  32'(bus4.oIouD),  0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_eq($sformatf("lw4_c%0d_state", c), 32'(bus4.oState),     32'(st_f4[c]));
      check_eq($sformatf("lw4_c%0d_irwr", c),  32'(bus4.oEscreveIR), 32'(c == 4));
      to_next();
    end

    // Single-cycle execute states
    run_to_exec(C_AUIPC);
    check_eq("auipc_state", 32'(bus0.oState),    13);
    check_eq("auipc_origa", 32'(bus0.oOrigAULA), 0);
    check_eq("auipc_origb", 32'(bus0.oOrigBULA), 2);
    check_eq("auipc_aluop", 32'(bus0.oALUOp),    0);
    to_next();
    @(negedge clk);
    check_eq("auipc_wb_state",   32'(bus0.oState),        8);
    check_eq("auipc_wb_retired", 32'(bus0.oInstrRetired), 1);

    run_to_exec(C_BRANCH);
    check_eq("br_state",   32'(bus0.oState),         9);
    check_eq("br_pccond",  32'(bus0.oEscrevePCCond), 1);
    check_eq("br_origpc",  32'(bus0.oOrigPC),        1);
    check_eq("br_aluop",   32'(bus0.oALUOp),         1);
    check_eq("br_retired", 32'(bus0.oInstrRetired),  1);

    run_to_exec(C_JAL);
    check_eq("jal_state",   32'(bus0.oState),     10);
    check_eq("jal_pcwr",    32'(bus0.oEscrevePC), 1);
    check_eq("jal_origpc",  32'(bus0.oOrigPC),    1);
    check_eq("jal_mem2reg", 32'(bus0.oMem2Reg),   1);
    check_eq("jal_regwr",   32'(bus0.oRegWrite),  1);

    run_to_exec(C_JALR);
    check_eq("jalr_state", 32'(bus0.oState),     11);
    check_eq("jalr_origa", 32'(bus0.oOrigAULA),  1);
    check_eq("jalr_origb", 32'(bus0.oOrigBULA),  2);
    check_eq("jalr_origpc", 32'(bus0.oOrigPC),   0);

    run_to_exec(C_LUI);
    check_eq("lui_state", 32'(bus0.oState),    12);
    check_eq("lui_origb", 32'(bus0.oOrigBULA), 2);
    check_eq("lui_aluop", 32'(bus0.oALUOp),    3);

    run_to_exec(C_OPIMM);
    check_eq("opimm_state", 32'(bus0.oState),    7);
    check_eq("opimm_origb", 32'(bus0.oOrigBULA), 2);
    check_eq("opimm_aluop", 32'(bus0.oALUOp),    2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
